// File: rtl/exec_core_pkg.sv
// rtl/exec_core_pkg.sv - shared opcodes, FSM encodings and instruction field positions
// Contents: OP_* opcode constants, state_t FSM encoding, instruction field bit
// positions, idx_ok() register-index range check.
package exec_core_pkg;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // A register field is in range when no bit at or above the index width is set.
    function automatic logic idx_ok(input logic [7:0] field, input int unsigned aw);
        return (field >> aw) == 8'd0;
    endfunction

endpackage

// File: rtl/alu_param.sv
// rtl/alu_param.sv - combinational ALU for the execution core
// Ports: op (opcode), a/b (operands), y (result), carry (add carry-out / sub borrow).
// Unknown opcodes produce y=0, carry=0.
module alu_param
    import exec_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_LOADI: y = b;
            OP_MOV:   y = a;
            OP_ADD:   {carry, y} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exec_core.sv
// rtl/exec_core.sv - multi-cycle execution core: register file, ALU, 4-state sequencer
// Ports: CLK, RESET (async, active-high); instr/instr_valid/instr_ready accept handshake;
// result/result_valid and illegal pulse in WB; busy while not IDLE.
// Optional: EXEC_CORE_FLAGS_EN adds flag_z/flag_c, updated by legal add/sub.
module exec_core
    import exec_core_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              illegal,
    output logic              busy
`ifdef EXEC_CORE_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    localparam int AW = $clog2(NUM_REGS);

    state_t state, state_n;

    logic [7:0]        op_q, rd_q, rs2_q, rs1_q;
    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] alu_y;
    logic              alu_carry;
    logic              ill_q;
    logic              bad;
    logic [DATA_W-1:0] imm_sext;

    // ---------------- sequencer ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        instr_ready  = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        illegal      = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) state_n = ST_DECODE;
            end
            ST_DECODE: state_n = ST_EXEC;
            ST_EXEC:   state_n = ST_WB;
            ST_WB: begin
                result_valid = ~ill_q;
                illegal      = ill_q;
                state_n      = ST_IDLE;
            end
            default:   state_n = ST_IDLE;
        endcase
    end

    // ---------------- decode ----------------
    // rs1 is only a register for mov..or, rs2 only for add..or.
    always_comb begin
        bad = 1'b0;
        if (op_q > OP_OR)
            bad = 1'b1;
        else if (!idx_ok(rd_q, AW))
            bad = 1'b1;
        else if (op_q != OP_LOADI && !idx_ok(rs1_q, AW))
            bad = 1'b1;
        else if (op_q >= OP_ADD && !idx_ok(rs2_q, AW))
            bad = 1'b1;
    end

    assign imm_sext = DATA_W'($signed(rs1_q));

    // ---------------- datapath ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q   <= '0;
            rd_q   <= '0;
            rs2_q  <= '0;
            rs1_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (instr_valid) begin
                    op_q  <= instr[OP_HI:OP_LO];
                    rd_q  <= instr[RD_HI:RD_LO];
                    rs2_q <= instr[RS2_HI:RS2_LO];
                    rs1_q <= instr[RS1_HI:RS1_LO];
                end
                // Operands are captured here, so rd aliasing rs1/rs2 sees the old value.
                ST_DECODE: begin
                    a_q <= rf[rs1_q[AW-1:0]];
                    b_q <= (op_q == OP_LOADI) ? imm_sext : rf[rs2_q[AW-1:0]];
                end
                ST_EXEC: begin
                    result <= bad ? '0 : alu_y;
                    ill_q  <= bad;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (state == ST_WB && !ill_q) begin
            rf[rd_q[AW-1:0]] <= result;
        end
    end

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

`ifdef EXEC_CORE_FLAGS_EN
    logic carry_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            carry_q <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            if (state == ST_EXEC) carry_q <= alu_carry;
            if (state == ST_WB && !ill_q && (op_q == OP_ADD || op_q == OP_SUB)) begin
                flag_z <= (result == '0);
                flag_c <= carry_q;
            end
        end
    end
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

endmodule

// File: tb/tb_exec_core.sv
// tb/tb_exec_core.sv - scoreboard bench for exec_core
module tb_exec_core;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  result;
    logic        result_valid;
    logic        illegal;
    logic        busy;
`ifdef EXEC_CORE_FLAGS_EN
    logic        flag_z, flag_c;
`endif

    exec_core #(.DATA_W(8), .NUM_REGS(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .result       (result),
        .result_valid (result_valid),
        .illegal      (illegal),
        .busy         (busy)
`ifdef EXEC_CORE_FLAGS_EN
        ,
        .flag_z       (flag_z),
        .flag_c       (flag_c)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ill;
        logic [7:0] res;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] m [8];
    logic       mz = 1'b0;
    logic       mc = 1'b0;

    function automatic logic [31:0] enc(input logic [7:0] op, rd, rs2, rs1);
        return {op, rd, rs2, rs1};
    endfunction

    // Reference model: computes the expected outcome and updates model state.
    task automatic push_expect(input logic [31:0] w);
        logic [7:0] op, rd, rs2, rs1, r;
        logic       ill, c;
        exp_t       e;
        op = w[31:24]; rd = w[23:16]; rs2 = w[15:8]; rs1 = w[7:0];
        ill = (op > 8'd5) || (rd > 8'd7) ||
              (op >= 8'd1 && op <= 8'd5 && rs1 > 8'd7) ||
              (op >= 8'd2 && op <= 8'd5 && rs2 > 8'd7);
        r = 8'd0;
        c = 1'b0;
        if (!ill) begin
            case (op)
                8'd0: r = rs1;
                8'd1: r = m[rs1[2:0]];
                8'd2: {c, r} = {1'b0, m[rs1[2:0]]} + {1'b0, m[rs2[2:0]]};
                8'd3: begin r = m[rs1[2:0]] - m[rs2[2:0]]; c = m[rs1[2:0]] < m[rs2[2:0]]; end
                8'd4: r = m[rs1[2:0]] & m[rs2[2:0]];
                default: r = m[rs1[2:0]] | m[rs2[2:0]];
            endcase
            m[rd[2:0]] = r;
            if (op == 8'd2 || op == 8'd3) begin
                mz = (r == 8'd0);
                mc = c;
            end
        end
        e.ill = ill;
        e.res = r;
        sb.push_back(e);
    endtask

    // Output monitor: every WB pulse must match the oldest scoreboard entry.
    always @(negedge CLK) begin
        if (result_valid || illegal) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: result_valid=%0b illegal=%0b result=%0d, required no output",
                         result_valid, illegal, result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({illegal, result_valid, result} !== {e.ill, ~e.ill, e.res}) begin
                    n_fail++;
                    $display("FAIL wb_output: illegal=%0b valid=%0b result=%0d, required illegal=%0b valid=%0b result=%0d",
                             illegal, result_valid, result, e.ill, ~e.ill, e.res);
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (instr_ready !== 1'b1 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        if (instr_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: instr_ready=%b, required 1", instr_ready);
        end
    endtask

    // Issues one instruction from a negedge and returns at the negedge after it retires.
    task automatic issue(input logic [31:0] w, input bit chk_ready);
        wait_idle();
        push_expect(w);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (chk_ready) begin
                n_cmp++;
                if (instr_ready !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_low_cyc%0d: instr_ready=%b busy=%b, required 0/1", i, instr_ready, busy);
                end
            end
        end
        @(negedge CLK);
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_return: instr_ready=%b, required 1", instr_ready);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({instr_ready, busy, result_valid, illegal, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b busy=%b rv=%b ill=%b result=%0d, required 1 0 0 0 0",
                     instr_ready, busy, result_valid, illegal, result);
        end
`ifdef EXEC_CORE_FLAGS_EN
        n_cmp++;
        if ({flag_z, flag_c} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: z=%b c=%b, required 0 0", flag_z, flag_c);
        end
`endif
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = 8'd0;
        mz = 1'b0;
        mc = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_loadi();
        issue(enc(8'd0, 8'd0, 8'd0, 8'd6), 1'b1);
        issue(enc(8'd0, 8'd1, 8'd0, 8'd2), 1'b1);
    endtask

    task automatic test_alu_ops();
        issue(enc(8'd2, 8'd2, 8'd1, 8'd0), 1'b0);
        issue(enc(8'd3, 8'd3, 8'd1, 8'd0), 1'b0);
        issue(enc(8'd4, 8'd4, 8'd1, 8'd0), 1'b0);
        issue(enc(8'd5, 8'd5, 8'd1, 8'd0), 1'b0);
        // sub with borrow and a negative immediate
        issue(enc(8'd3, 8'd5, 8'd0, 8'd1), 1'b0);
        issue(enc(8'd0, 8'd5, 8'd0, 8'hF0), 1'b0);
    endtask

    task automatic test_wrap_flags();
        issue(enc(8'd0, 8'd6, 8'd0, 8'hFF), 1'b0);
        issue(enc(8'd0, 8'd7, 8'd0, 8'd1), 1'b0);
        issue(enc(8'd2, 8'd6, 8'd7, 8'd6), 1'b0);
`ifdef EXEC_CORE_FLAGS_EN
        n_cmp++;
        if ({flag_z, flag_c} !== {mz, mc}) begin
            n_fail++;
            $display("FAIL flags_wrap: z=%b c=%b, required %b %b", flag_z, flag_c, mz, mc);
        end
        // a logic op must leave the flags alone
        issue(enc(8'd5, 8'd3, 8'd1, 8'd0), 1'b0);
        n_cmp++;
        if ({flag_z, flag_c} !== {mz, mc}) begin
            n_fail++;
            $display("FAIL flags_hold: z=%b c=%b, required %b %b", flag_z, flag_c, mz, mc);
        end
`endif
    endtask

    task automatic readback_all();
        for (int i = 0; i < 8; i++)
            issue(enc(8'd1, 8'(i), 8'd0, 8'(i)), 1'b0);
    endtask

    task automatic test_illegal();
        issue(enc(8'd7, 8'd0, 8'd0, 8'd0), 1'b1);
        issue(enc(8'd0, 8'd8, 8'd0, 8'd3), 1'b0);
        issue(enc(8'd1, 8'd0, 8'd0, 8'd9), 1'b0);
        issue(enc(8'd2, 8'd0, 8'd8, 8'd1), 1'b0);
        readback_all();
    endtask

    task automatic test_reset_abort();
        wait_idle();
        instr       = enc(8'd2, 8'd2, 8'd1, 8'd0);
        instr_valid = 1'b1;
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: instr_ready=%b busy=%b, required 1 0", instr_ready, busy);
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = 8'd0;
        mz = 1'b0;
        mc = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: instr_ready=%b, required 1", instr_ready);
        end
        issue(enc(8'd1, 8'd2, 8'd0, 8'd2), 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        int          acc[$];
        w[0] = enc(8'd0, 8'd1, 8'd0, 8'd5);
        w[1] = enc(8'd2, 8'd2, 8'd1, 8'd1);
        w[2] = enc(8'd3, 8'd3, 8'd1, 8'd2);
        wait_idle();
        for (int k = 0; k < 3; k++) push_expect(w[k]);
        for (int cyc = 0; cyc < 12; cyc++) begin
            instr       = w[cyc / 4];
            instr_valid = 1'b1;
            #1;
            if (instr_ready === 1'b1) acc.push_back(cyc);
            @(posedge CLK);
            @(negedge CLK);
        end
        instr_valid = 1'b0;
        n_cmp++;
        if (acc.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d, required 3", acc.size());
        end else begin
            n_cmp++;
            if (acc[0] != 0 || acc[1] != 4 || acc[2] != 8) begin
                n_fail++;
                $display("FAIL b2b_spacing: accept cycles %0d %0d %0d, required 0 4 8", acc[0], acc[1], acc[2]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 8'd0;
        test_reset();
        test_loadi();
        test_alu_ops();
        test_wrap_flags();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        repeat (6) @(negedge CLK);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
